dsp_mem_stage: RTL
==================

Name: dsp_mem_stage

Overview:
- Memory-access stage of the DSP pipeline. Sits between execute and write-back.
- Takes execute results, performs single-word loads/stores on the data-memory bus via a req/ack handshake, and stalls execute while a transfer is outstanding.
- Delivers write-back data and a registered one-cycle write-enable to the write-back stage, which gates the register-file write on the low clock phase.

Parameters:
- DATA_W, 16, register word width; equals the codebase register word length.
- ADDR_W, 16, data-memory address width.
- RD_W, 4, destination register index width.
- TIMEOUT, 15, max cycles waiting for dmem_ack before abort (1..255).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous reset, active-high.
- ex_valid  input  1  execute stage presents an operation.
- ex_ready  output  1  stage can accept; transfer when ex_valid & ex_ready.
- ex_result  input  DATA_W  ALU result; address for load/store, data otherwise.
- ex_store_data  input  DATA_W  store data.
- ex_is_load  input  1  operation is a load.
- ex_is_store  input  1  operation is a store.
- ex_write_back_en  input  1  decode requests register write.
- ex_rd  input  RD_W  destination register.
- dmem_req  output  1  bus request, held until ack.
- dmem_we  output  1  1 = write.
- dmem_addr  output  ADDR_W  bus address.
- dmem_wdata  output  DATA_W  bus write data.
- dmem_rdata  input  DATA_W  bus read data, valid with ack.
- dmem_ack  input  1  bus completion.
- mem_out  output  DATA_W  data to write-back.
- write_back_en  output  1  write-back enable, one-cycle pulse per retired op.
- wb_rd  output  RD_W  destination register for mem_out.
- mem_err  output  1  one-cycle pulse on bus timeout.

Behaviour:
- Reset (async, immediate): state IDLE; dmem_req, dmem_we, write_back_en, mem_err = 0; mem_out, dmem_addr, dmem_wdata, wb_rd = 0; timeout counter = 0. Reset mid-transfer drops dmem_req immediately; the in-flight op is discarded with no write-back.
- States: IDLE, BUSY.
- ex_ready = (state == IDLE). Combinational from state only; no path from ex_valid or dmem_ack.
- IDLE, accepted op, no load/store: next cycle mem_out = ex_result, wb_rd = ex_rd, write_back_en = ex_write_back_en. Latency 1; back-to-back accepts give one result per cycle.
- IDLE, accepted store: next cycle dmem_req = 1, dmem_we = 1, dmem_addr = ex_result[ADDR_W-1:0], dmem_wdata = ex_store_data; go BUSY. Stores never assert write_back_en, regardless of ex_write_back_en.
- IDLE, accepted load: same, with dmem_we = 0; go BUSY. Capture ex_rd and ex_write_back_en.
- ex_is_load and ex_is_store both high: treated as store.
- BUSY: dmem_req, dmem_we, dmem_addr, dmem_wdata held stable. Counter increments each BUSY cycle.
- BUSY, dmem_ack = 1: next cycle dmem_req = 0 and state = IDLE. For a load, mem_out = dmem_rdata, wb_rd = captured rd, write_back_en = captured ex_write_back_en, all in that same next cycle. Counter cleared.
- Ack is sampled only in BUSY. Earliest ack is the first cycle dmem_req is high, giving minimum load latency of 2 cycles from accept.
- dmem_ack while IDLE: ignored.
- BUSY with counter reaching TIMEOUT and no ack: next cycle dmem_req = 0, state = IDLE, mem_err pulses 1 cycle, no write-back. Ack arriving on the same cycle as the timeout wins: normal completion, no error.
- ex_ready is 0 for the whole BUSY period and also on the completion cycle. A new op is accepted the cycle after the state returns to IDLE.
- write_back_en is registered and glitch-free, high for exactly one full clock period per retired op. It is 0 in every cycle with no retirement. mem_out and wb_rd hold their last value otherwise.
- ex_* inputs are don't-care when ex_valid = 0 or ex_ready = 0.

Test Plan:
- Reset then ALU op: ex_result = 0x1234, rd = 3, wb_en = 1 -> next cycle mem_out = 0x1234, wb_rd = 3, write_back_en = 1 for 1 cycle; three back-to-back ops give three consecutive pulses.
- Load addr 0x0040, ack 3 cycles after req with rdata = 0xBEEF -> dmem_req high 3 cycles, addr stable, ex_ready = 0 throughout; then mem_out = 0xBEEF, write_back_en = 1 for 1 cycle.
- Store addr 0x0010, data 0x5A5A, wb_en = 1, ack immediate -> dmem_we = 1, wdata = 0x5A5A; write_back_en stays 0; ex_ready returns to 1 two cycles after accept.
- Load with no ack, TIMEOUT = 15 -> req drops after 15 BUSY cycles, mem_err pulses once, no write_back_en; ack exactly at cycle 15 -> normal completion, mem_err = 0.
- Assert rst while BUSY on a load -> dmem_req = 0 immediately, all outputs 0; a late ack after reset causes no write_back_en.
- Stray dmem_ack while IDLE, and load+store both high with addr 0x0020 -> stray ack ignored; op issues with dmem_we = 1 and no write-back.

Source files
------------

// File: rtl/dsp_mem_stage.sv
// Memory-access pipeline stage: passes ALU results through and runs single-word
// loads/stores on the data-memory req/ack bus, stalling execute while busy.
module dsp_mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic              ex_write_back_en,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] mem_out,
    output logic              write_back_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic              mem_err
);
    // state | meaning
    // IDLE  | accepting ops; ALU results retire here with one-cycle latency
    // BUSY  | bus transfer outstanding, dmem_req high, execute stalled

    typedef enum logic {IDLE, BUSY} state_t;

    // Terminal count: the TIMEOUT-th BUSY cycle without ack aborts.
    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

    state_t            state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic              is_load_q, is_load_d;
    logic              wb_en_q, wb_en_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] mem_out_d;
    logic [RD_W-1:0]   wb_rd_d;
    logic              write_back_en_d;
    logic              mem_err_d;

    // Request follows the state so a reset drops it in the same instant.
    assign ex_ready = (state == IDLE);
    assign dmem_req = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_load_q     <= 1'b0;
            wb_en_q       <= 1'b0;
            rd_q          <= '0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            mem_out       <= '0;
            wb_rd         <= '0;
            write_back_en <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            is_load_q     <= is_load_d;
            wb_en_q       <= wb_en_d;
            rd_q          <= rd_d;
            dmem_we       <= we_d;
            dmem_addr     <= addr_d;
            dmem_wdata    <= wdata_d;
            mem_out       <= mem_out_d;
            wb_rd         <= wb_rd_d;
            write_back_en <= write_back_en_d;
            mem_err       <= mem_err_d;
        end
    end

    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        is_load_d       = is_load_q;
        wb_en_d         = wb_en_q;
        rd_d            = rd_q;
        we_d            = dmem_we;
        addr_d          = dmem_addr;
        wdata_d         = dmem_wdata;
        mem_out_d       = mem_out;
        wb_rd_d         = wb_rd;
        write_back_en_d = 1'b0;
        mem_err_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load || ex_is_store) begin
                        // Store takes priority when both flags are set.
                        state_d   = BUSY;
                        cnt_d     = '0;
                        we_d      = ex_is_store;
                        is_load_d = !ex_is_store;
                        addr_d    = ex_result[ADDR_W-1:0];
                        wdata_d   = ex_store_data;
                        rd_d      = ex_rd;
                        wb_en_d   = ex_write_back_en;
                    end else begin
                        mem_out_d       = ex_result;
                        wb_rd_d         = ex_rd;
                        write_back_en_d = ex_write_back_en;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (is_load_q) begin
                        mem_out_d       = dmem_rdata;
                        wb_rd_d         = rd_q;
                        write_back_en_d = wb_en_q;
                    end
                end else if (cnt == TERM_CNT) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
